serial_add_ctrl: RTL and testbench

- Sequencer that time-shares one 1-bit full-adder cell to perform a WIDTH-bit addition, one bit per clock, LSB first.
- Accepts operands over a valid/ready handshake, owns the carry flip-flop and bit counter, and returns sum and carry-out over a second valid/ready handshake.
- Sits between operand producers and consumers wherever area matters more than latency.

---
 rtl/serial_add_pkg.sv | 17 +
 rtl/full_adder_cell.sv | 13 +
 rtl/serial_add_ctrl.sv | 105 ++++++++++
 tb/tb_serial_add_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
package serial_add_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bit-counter width for a given operand width; never less than one bit.
   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder; the only arithmetic element of the serial adder.
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, one bit per clock, LSB first.
// Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output out_ovf.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             busy
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             out_ovf
`endif
);

   localparam int               CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   // Holds the WIDTH-1 sum bits already produced; the cell supplies the newest bit.
   logic [WIDTH-2:0] sum_sr;
   logic [WIDTH-1:0] sum_next;
   logic             carry;
   logic [CNT_W-1:0] counter;
   logic             cell_s;
   logic             cell_cout;

   full_adder_cell u_cell (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .cin  (carry),
      .s    (cell_s),
      .cout (cell_cout)
   );

   assign sum_next  = {cell_s, sum_sr};
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

   // NOTE: every register here, datapath included, is reset so an aborted
   // operation leaves nothing behind; all updates use non-blocking assignments.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         a_sr     <= '0;
         b_sr     <= '0;
         sum_sr   <= '0;
         carry    <= 1'b0;
         counter  <= '0;
         out_sum  <= '0;
         out_cout <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         out_ovf  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sr    <= in_a;
                  b_sr    <= in_b;
                  carry   <= in_cin;
                  counter <= '0;
                  state   <= RUN;
               end
            end
            RUN: begin
               sum_sr <= sum_next[WIDTH-1:1];
               carry  <= cell_cout;
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               if (counter == LAST_BIT) begin
                  counter  <= '0;
                  out_sum  <= sum_next;
                  out_cout <= cell_cout;
`ifdef SERIAL_ADD_OVF_EN
                  // carry still holds the carry into the MSB on this last step
                  out_ovf  <= carry ^ cell_cout;
`endif
                  state    <= DONE;
               end else begin
                  counter <= counter + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): vector table, corner sequences,
// and randomized back-to-back traffic against an arithmetic reference model.
module tb_serial_add_ctrl;
   import serial_add_pkg::*;

   localparam int W     = 8;
   localparam int N_RND = 1000;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_cin = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         in_ready;
   logic         out_valid;
   logic         out_cout;
   logic         busy;
   logic [W-1:0] out_sum;
`ifdef SERIAL_ADD_OVF_EN
   logic         out_ovf;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .busy      (busy)
`ifdef SERIAL_ADD_OVF_EN
      ,
      .out_ovf   (out_ovf)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] sum;
      logic         cout;
   } vec_t;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } exp_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain unsigned addition, overflow from operand/result signs.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
      exp_t        e;
      logic [W:0]  full;
      full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      e.sum  = full[W-1:0];
      e.cout = full[W];
      e.ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
      return e;
   endfunction

   // Presents operands at a falling edge; they are taken on the next rising edge.
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_cin   = cin;
      check("accept_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_a     = W'($urandom);
      in_b     = W'($urandom);
      in_cin   = 1'($urandom);
   endtask

   // Counts rising edges after the accept edge until out_valid is seen.
   task automatic wait_valid(output int lat, output bit busy_ok);
      lat     = 0;
      busy_ok = 1'b1;
      @(negedge clk);
      while (!out_valid && lat < 4 * W) begin
         if (!busy) busy_ok = 1'b0;
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      if (!busy) busy_ok = 1'b0;
   endtask

   task automatic pop();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         output logic [W-1:0] sum, output logic cout, output logic ovf,
                         output int lat, output bit busy_ok);
      start_op(a, b, cin);
      wait_valid(lat, busy_ok);
      sum  = out_sum;
      cout = out_cout;
`ifdef SERIAL_ADD_OVF_EN
      ovf  = out_ovf;
`else
      ovf  = 1'b0;
`endif
      pop();
   endtask

   initial begin
      vec_t         vecs[5];
      exp_t         q[$];
      exp_t         e;
      logic [W-1:0] s;
      logic         c;
      logic         v;
      int           lat;
      bit           busy_ok;
      bit           stable_ok;
      int           acc, res, cyc, last_acc;

      vecs[0] = '{a: 8'h5A, b: 8'h33, cin: 1'b0, sum: 8'h8D, cout: 1'b0};
      vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1};
      vecs[2] = '{a: 8'hFF, b: 8'h00, cin: 1'b1, sum: 8'h00, cout: 1'b1};
      vecs[3] = '{a: 8'h00, b: 8'h00, cin: 1'b1, sum: 8'h01, cout: 1'b0};
      vecs[4] = '{a: 8'hC3, b: 8'h3C, cin: 1'b1, sum: 8'h00, cout: 1'b1};

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_sum_cout", {out_cout, out_sum}, '0);
      rst_n = 1'b1;

      // Directed vector table
      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].cin, s, c, v, lat, busy_ok);
         check($sformatf("vec%0d_sum", i), s, vecs[i].sum);
         check($sformatf("vec%0d_cout", i), c, vecs[i].cout);
         check($sformatf("vec%0d_latency", i), lat, W);
         check($sformatf("vec%0d_busy", i), busy_ok, 1'b1);
         @(negedge clk);
         check($sformatf("vec%0d_idle_after", i), {in_ready, busy, out_valid}, 3'b100);
      end

      // Hold in DONE with a competing request pending
      start_op(8'h5A, 8'h33, 1'b0);
      wait_valid(lat, busy_ok);
      in_valid  = 1'b1;
      in_a      = 8'h11;
      in_b      = 8'h22;
      in_cin    = 1'b0;
      stable_ok = 1'b1;
      repeat (5) begin
         @(posedge clk);
         @(negedge clk);
         if (!out_valid || out_sum !== 8'h8D || out_cout !== 1'b0 || in_ready || !busy)
            stable_ok = 1'b0;
      end
      check("hold_stable", stable_ok, 1'b1);
      pop();
      @(negedge clk);
      check("hold_idle_ready", {in_ready, out_valid}, 2'b10);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_a     = 8'hFF;
      in_b     = 8'hFF;
      wait_valid(lat, busy_ok);
      check("hold_next_sum", {out_cout, out_sum}, 9'h033);
      check("hold_next_latency", lat, W);
      pop();

      // Asynchronous reset mid-operation
      start_op(8'hAA, 8'h55, 1'b0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", out_valid, 1'b0);
      check("arst_in_ready", in_ready, 1'b1);
      check("arst_busy", busy, 1'b0);
      check("arst_sum_cout", {out_cout, out_sum}, '0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      stable_ok = 1'b1;
      repeat (W + 2) begin
         @(negedge clk);
         if (out_valid || busy) stable_ok = 1'b0;
      end
      check("arst_no_output", stable_ok, 1'b1);
      run_op(8'h10, 8'h20, 1'b0, s, c, v, lat, busy_ok);
      check("arst_next_sum", {c, s}, 9'h030);
      check("arst_next_latency", lat, W);

`ifdef SERIAL_ADD_OVF_EN
      run_op(8'h7F, 8'h01, 1'b0, s, c, v, lat, busy_ok);
      check("ovf0_sum", s, 8'h80);
      check("ovf0_flags", {c, v}, 2'b01);
      run_op(8'h80, 8'h80, 1'b0, s, c, v, lat, busy_ok);
      check("ovf1_sum", s, 8'h00);
      check("ovf1_flags", {c, v}, 2'b11);
      run_op(8'h40, 8'h30, 1'b0, s, c, v, lat, busy_ok);
      check("ovf2_sum", s, 8'h70);
      check("ovf2_flags", {c, v}, 2'b00);
`endif

      // Back-to-back random traffic, both handshakes held high
      acc       = 0;
      res       = 0;
      cyc       = 0;
      last_acc  = 0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      while (res < N_RND && cyc < 12 * N_RND) begin
         @(negedge clk);
         if (acc >= N_RND) in_valid = 1'b0;
         if (out_valid) begin
            check("rand_expected_pending", q.size() != 0, 1'b1);
            if (q.size() != 0) begin
               e = q.pop_front();
               check($sformatf("rand%0d_sum", res), {out_cout, out_sum}, {e.cout, e.sum});
`ifdef SERIAL_ADD_OVF_EN
               check($sformatf("rand%0d_ovf", res), out_ovf, e.ovf);
`endif
            end
            res++;
         end
         in_a   = W'($urandom);
         in_b   = W'($urandom);
         in_cin = 1'($urandom);
         if (in_ready && in_valid) begin
            q.push_back(model(in_a, in_b, in_cin));
            if (acc > 0) check("rand_interval", cyc - last_acc, W + 2);
            last_acc = cyc;
            acc++;
         end
         @(posedge clk);
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("rand_result_count", res, N_RND);
      check("rand_queue_drained", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
